alimentador_divisor: RTL

//  Upstream feeder for the pipelined divider. Buffers operand pairs in a DEPTH-entry FIFO,

---
 rtl/alimentador_divisor.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/alimentador_divisor.sv
// alimentador_divisor: upstream feeder for the pipelined divider.
//
// Operand pairs are queued in a DEPTH-entry circular FIFO. Entries are issued one at a time to the
// divider with the inicie/termino handshake. Each returned cociente is captured into resultado,
// with a one-cycle resultado_valido pulse. Entries with a zero divisor are never issued. They are
// dropped, one per cycle, with a one-cycle error_div0 pulse.
//
// Ports
//   reloj, reset          clock (rising edge) and asynchronous active-high reset
//   escriba, dd_in, dv_in push request and operand pair
//   lleno, pendientes     FIFO full flag and occupancy (0..DEPTH)
//   dividendo, divisor    registered operands to the divider, held while an op is in flight
//   inicie                registered go to the divider
//   termino, cociente     divider ready/done and its quotient
//   resultado             last captured quotient
//   resultado_valido      one-cycle pulse when resultado updates
//   error_div0            one-cycle pulse when a zero-divisor entry is dropped
//   ocupado               an operation is in progress (state other than idle)
`timescale 1ns / 1ps

module alimentador_divisor #(
  parameter int unsigned DD_LEN = 32,
  parameter int unsigned DV_LEN = 16,
  parameter int unsigned Q_LEN  = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PTR_W  = 2
) (
  input  logic              reloj,
  input  logic              reset,
  input  logic              escriba,
  input  logic [DD_LEN-1:0] dd_in,
  input  logic [DV_LEN-1:0] dv_in,
  output logic              lleno,
  output logic [PTR_W:0]    pendientes,
  output logic [DD_LEN-1:0] dividendo,
  output logic [DV_LEN-1:0] divisor,
  output logic              inicie,
  input  logic              termino,
  input  logic [Q_LEN-1:0]  cociente,
  output logic [Q_LEN-1:0]  resultado,
  output logic              resultado_valido,
  output logic              error_div0,
  output logic              ocupado
);

  localparam logic [PTR_W:0] DepthCnt = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    StReposo,
    StLanza,
    StEspera,
    StCaptura
  } estado_e;

  estado_e estado_q, estado_d;

  // FIFO storage and pointers. Pointers are PTR_W bits wide, so they wrap DEPTH-1 -> 0 naturally.
  logic [DD_LEN-1:0] fifo_dd_q [DEPTH];
  logic [DV_LEN-1:0] fifo_dv_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]    cnt_q, cnt_d;

  logic [DD_LEN-1:0] dividendo_q;
  logic [DV_LEN-1:0] divisor_q;
  logic              inicie_q;
  logic [Q_LEN-1:0]  resultado_q;
  logic              resultado_valido_q;
  logic              error_div0_q;

  logic              pop, push, emite, descarta;
  logic [DD_LEN-1:0] head_dd;
  logic [DV_LEN-1:0] head_dv;

  assign head_dd = fifo_dd_q[rd_ptr_q];
  assign head_dv = fifo_dv_q[rd_ptr_q];

  assign lleno = (cnt_q == DepthCnt);

  // The head is consumed only from idle, and only while the divider reports ready.
  assign pop      = (estado_q == StReposo) && (cnt_q != '0) && termino;
  assign descarta = pop && (head_dv == '0);
  assign emite    = pop && (head_dv != '0);

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push = escriba && (!lleno || pop);

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      StReposo:  if (emite) estado_d = StLanza;
      StLanza:   if (!termino) estado_d = StEspera;  // divider accepted the op
      StEspera:  if (termino) estado_d = StCaptura;
      StCaptura: estado_d = StReposo;
      default:   estado_d = StReposo;
    endcase
  end

  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      estado_q           <= StReposo;
      rd_ptr_q           <= '0;
      wr_ptr_q           <= '0;
      cnt_q              <= '0;
      dividendo_q        <= '0;
      divisor_q          <= '0;
      inicie_q           <= 1'b0;
      resultado_q        <= '0;
      resultado_valido_q <= 1'b0;
      error_div0_q       <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (emite) begin
        dividendo_q <= head_dd;
        divisor_q   <= head_dv;
      end
      inicie_q     <= (estado_d == StLanza);
      error_div0_q <= descarta;
      // Capture on the termino rise so resultado and its valid pulse appear together.
      if ((estado_q == StEspera) && termino) resultado_q <= cociente;
      resultado_valido_q <= (estado_d == StCaptura);
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are meaningful.
  always_ff @(posedge reloj) begin
    if (push) begin
      fifo_dd_q[wr_ptr_q] <= dd_in;
      fifo_dv_q[wr_ptr_q] <= dv_in;
    end
  end

  assign pendientes       = cnt_q;
  assign dividendo        = dividendo_q;
  assign divisor          = divisor_q;
  assign inicie           = inicie_q;
  assign resultado        = resultado_q;
  assign resultado_valido = resultado_valido_q;
  assign error_div0       = error_div0_q;
  assign ocupado          = (estado_q != StReposo);

endmodule
